// File: rtl/baud_gen_frac.sv
// baud_gen_frac -- fractional baud tick generator for the UART TX/RX path.
//
// Produces an oversample tick (OVERSAMPLE x baud) and a 1x baud tick from a
// runtime-programmable divisor of DIV_INT + DIV_FRAC/2^FRAC_W clock cycles per
// oversample period. The fractional part is spread by a FRAC_W-bit phase
// accumulator whose carry stretches a period by one cycle.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        synchronous active-high reset, restores the default divisor
//   i_enable       run tick generation; low holds the counters idle
//   i_div_int      integer cycles per oversample period
//   i_div_frac     fractional cycles per oversample period (1/2^FRAC_W units)
//   i_div_load     strobe capturing i_div_int/i_div_frac into the shadow divisor
//   i_resync       (BAUD_GEN_RESYNC_EN builds only) restart the bit timing
//   o_load_pending shadow divisor not yet applied
//   o_cfg_err      active integer divisor below 2, clamped to 2
//   o_os_tick      one-cycle oversample tick
//   o_baud_tick    one-cycle baud tick, coincident with the last o_os_tick of a bit
//   o_phase        oversample index of the most recent o_os_tick within the bit
//
// Build option: define BAUD_GEN_RESYNC_EN to add the i_resync port and logic.

module baud_gen_frac #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FRAC_W     = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic [DIV_W-1:0]              i_div_int,
    input  logic [FRAC_W-1:0]             i_div_frac,
    input  logic                          i_div_load,
`ifdef BAUD_GEN_RESYNC_EN
    input  logic                          i_resync,
`endif
    output logic                          o_load_pending,
    output logic                          o_cfg_err,
    output logic                          o_os_tick,
    output logic                          o_baud_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] o_phase
);

    localparam int unsigned PH_W = $clog2(OVERSAMPLE);

    localparam logic [63:0] OS_RATE  = 64'(BAUD_RATE) * 64'(OVERSAMPLE);
    localparam logic [63:0] DEF_I64  = 64'(CLK_FREQ) / OS_RATE;
    localparam logic [63:0] DEF_F64  = (64'(CLK_FREQ) << FRAC_W) / OS_RATE;
    localparam logic [DIV_W-1:0]  DEF_INT  = DEF_I64[DIV_W-1:0];
    localparam logic [FRAC_W-1:0] DEF_FRAC = DEF_F64[FRAC_W-1:0];
    localparam logic [DIV_W-1:0]  DEF_EFF  = (DEF_INT < DIV_W'(2)) ? DIV_W'(2) : DEF_INT;

    logic [DIV_W-1:0]  act_int, shd_int, cnt;
    logic [FRAC_W-1:0] act_frac, shd_frac, acc;
    logic              pend;
    logic [PH_W-1:0]   ph;

    logic [DIV_W-1:0]  nx_int, nx_eff, idle_cnt, reload_cnt;
    logic [FRAC_W-1:0] nx_frac;
    logic [FRAC_W:0]   acc_sum;
    logic              resync;
    logic              boundary;
    logic              apply;
    logic              ph_last;

`ifdef BAUD_GEN_RESYNC_EN
    assign resync = i_resync;
`else
    assign resync = 1'b0;
`endif

    // The divisor used from the next period on: a pending shadow value is
    // taken at any apply point (idle, resync, os-tick boundary). Because pend
    // is a register, a load in the same cycle as a boundary misses it.
    always_comb begin
        nx_int     = pend ? shd_int  : act_int;
        nx_frac    = pend ? shd_frac : act_frac;
        nx_eff     = (nx_int < DIV_W'(2)) ? DIV_W'(2) : nx_int;
        idle_cnt   = nx_eff - DIV_W'(1);
        acc_sum    = {1'b0, acc} + {1'b0, nx_frac};
        reload_cnt = idle_cnt + DIV_W'(acc_sum[FRAC_W]);
        boundary   = (cnt == '0);
        apply      = !i_enable || resync || boundary;
        ph_last    = (ph == PH_W'(OVERSAMPLE - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            act_int        <= DEF_INT;
            act_frac       <= DEF_FRAC;
            shd_int        <= DEF_INT;
            shd_frac       <= DEF_FRAC;
            pend           <= 1'b0;
            cnt            <= DEF_EFF - DIV_W'(1);
            acc            <= '0;
            ph             <= '0;
            o_phase        <= '0;
            o_os_tick      <= 1'b0;
            o_baud_tick    <= 1'b0;
            o_cfg_err      <= 1'b0;
            o_load_pending <= 1'b0;
        end else begin
            o_os_tick   <= 1'b0;
            o_baud_tick <= 1'b0;

            if (!i_enable || resync) begin
                // Idle and resync share the same restart state; no tick.
                cnt     <= idle_cnt;
                acc     <= '0;
                ph      <= '0;
                o_phase <= '0;
            end else if (boundary) begin
                o_os_tick   <= 1'b1;
                o_baud_tick <= ph_last;
                o_phase     <= ph;
                ph          <= ph_last ? '0 : ph + PH_W'(1);
                acc         <= acc_sum[FRAC_W-1:0];
                cnt         <= reload_cnt;
            end else begin
                cnt <= cnt - DIV_W'(1);
            end

            if (apply) begin
                act_int  <= nx_int;
                act_frac <= nx_frac;
            end
            o_cfg_err <= ((apply ? nx_int : act_int) < DIV_W'(2));

            if (i_div_load) begin
                shd_int        <= i_div_int;
                shd_frac       <= i_div_frac;
                pend           <= 1'b1;
                o_load_pending <= 1'b1;
            end else if (apply) begin
                pend           <= 1'b0;
                o_load_pending <= 1'b0;
            end
        end
    end

endmodule
